prim_clock_mux_sel_ctrl: RTL and testbench

Sequencer that generates the select for a two-input clock mux and the enable for the clock gate on the mux output. A switch request runs in a fixed order: gate the output off, wait, flip the select, wait for the mux to settle, re-enable, then acknowledge. The block sits directly upstream of the clock mux's select input and runs on an always-on clock that is not one of the two muxed clocks.

---
 rtl/prim_clock_mux_sel_ctrl.sv | 147 ++++++++++++++
 tb/tb_prim_clock_mux_sel_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_clock_mux_sel_ctrl.sv
// prim_clock_mux_sel_ctrl
//
// Sequencer for a glitch-free two-input clock mux. The block drives the mux
// select and the enable of the clock gate that follows the mux. A switch
// request runs in a fixed order:
//   1. Gate the output clock off.
//   2. Wait GateCycles cycles.
//   3. Flip the select.
//   4. Wait SettleCycles cycles for the mux to settle.
//   5. Re-enable the gate and pulse ack.
// The block runs on an always-on clock that is neither of the muxed clocks.
//
// Ports:
//   clk_i      - always-on controller clock
//   rst_ni     - synchronous, active-low reset
//   req_i      - single-cycle switch request pulse
//   sel_req_i  - target select, sampled only when req_i is accepted in IDLE
//   sel_o      - registered mux select (0 = clk0, 1 = clk1)
//   clk_en_o   - registered enable for the output clock gate
//   busy_o     - high while a switch is in progress
//   ack_o      - single-cycle completion pulse (also used for no-op requests)
//   req_drop_o - single-cycle pulse when req_i arrives while busy

module prim_clock_mux_sel_ctrl #(
    parameter int unsigned GateCycles   = 4,
    parameter int unsigned SettleCycles = 4,
    parameter logic        ResetSel     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic sel_req_i,
    output logic sel_o,
    output logic clk_en_o,
    output logic busy_o,
    output logic ack_o,
    output logic req_drop_o
);

    // The 8-bit down-counter bounds both wait phases to 1..255 cycles.
    if (GateCycles == 0 || GateCycles > 255) begin : gen_gate_range_err
        $error("prim_clock_mux_sel_ctrl: GateCycles must be in 1..255");
    end

    if (SettleCycles == 0 || SettleCycles > 255) begin : gen_settle_range_err
        $error("prim_clock_mux_sel_ctrl: SettleCycles must be in 1..255");
    end

    localparam logic [7:0] GateLoad   = 8'(GateCycles - 1);
    localparam logic [7:0] SettleLoad = 8'(SettleCycles - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        SETTLE = 2'd2
    } state_e;

    state_e     state;
    logic [7:0] count;
    logic       target;

    // Single sequential process: the state, the phase counter and every
    // output are registered here, so no input reaches an output
    // combinationally.
    //
    // The counter is loaded with N-1 on entry to a phase. The phase ends in
    // the cycle the counter reads zero, so each phase lasts exactly N cycles.
    //
    // sel_o is only updated at the end of GATE, while clk_en_o is already
    // low. clk_en_o only rises at the end of SETTLE. The select therefore
    // never moves while the gate is open.
    //
    // ack_o and req_drop_o default low every cycle, which makes them
    // single-cycle pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            count      <= 8'd0;
            target     <= ResetSel;
            sel_o      <= ResetSel;
            clk_en_o   <= 1'b1;
            busy_o     <= 1'b0;
            ack_o      <= 1'b0;
            req_drop_o <= 1'b0;
        end else begin
            ack_o      <= 1'b0;
            req_drop_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_i) begin
                        if (sel_req_i != sel_o) begin
                            target   <= sel_req_i;
                            state    <= GATE;
                            count    <= GateLoad;
                            clk_en_o <= 1'b0;
                            busy_o   <= 1'b1;
                        end else begin
                            // Already on the requested clock: acknowledge
                            // without touching the gate.
                            ack_o <= 1'b1;
                        end
                    end
                end

                GATE: begin
                    // Requests during a switch are refused. sel_req_i is
                    // not looked at.
                    if (req_i) begin
                        req_drop_o <= 1'b1;
                    end
                    if (count == 8'd0) begin
                        sel_o <= target;
                        state <= SETTLE;
                        count <= SettleLoad;
                    end else begin
                        count <= count - 8'd1;
                    end
                end

                SETTLE: begin
                    if (req_i) begin
                        req_drop_o <= 1'b1;
                    end
                    if (count == 8'd0) begin
                        state    <= IDLE;
                        clk_en_o <= 1'b1;
                        busy_o   <= 1'b0;
                        ack_o    <= 1'b1;
                    end else begin
                        count <= count - 8'd1;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a safe,
                    // ungated idle.
                    state    <= IDLE;
                    count    <= 8'd0;
                    clk_en_o <= 1'b1;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prim_clock_mux_sel_ctrl.sv
// tb_prim_clock_mux_sel_ctrl
//
// Drives three instances of the select controller, each with its own
// parameters:
//   inst0: G=4,   S=4
//   inst1: G=1,   S=1
//   inst2: G=255, S=255
//
// A cycle-count model predicts every output of every instance. It tracks
// how many edges have passed since a switch was accepted and derives the
// outputs from the phase lengths. A negedge process compares each instance
// against this model on every cycle. Directed sequences additionally pin
// literal, hand-derived values at key cycles.

module tb_prim_clock_mux_sel_ctrl;

    localparam int G0 = 4;
    localparam int S0 = 4;
    localparam int G1 = 1;
    localparam int S1 = 1;
    localparam int G2 = 255;
    localparam int S2 = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] sel_req;
    logic [2:0] sel;
    logic [2:0] clk_en;
    logic [2:0] busy;
    logic [2:0] ack;
    logic [2:0] drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prim_clock_mux_sel_ctrl #(
        .GateCycles(G0),
        .SettleCycles(S0),
        .ResetSel(1'b0)
    ) u_dut0 (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_i(req[0]),
        .sel_req_i(sel_req[0]),
        .sel_o(sel[0]),
        .clk_en_o(clk_en[0]),
        .busy_o(busy[0]),
        .ack_o(ack[0]),
        .req_drop_o(drop[0])
    );

    prim_clock_mux_sel_ctrl #(
        .GateCycles(G1),
        .SettleCycles(S1),
        .ResetSel(1'b0)
    ) u_dut1 (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_i(req[1]),
        .sel_req_i(sel_req[1]),
        .sel_o(sel[1]),
        .clk_en_o(clk_en[1]),
        .busy_o(busy[1]),
        .ack_o(ack[1]),
        .req_drop_o(drop[1])
    );

    prim_clock_mux_sel_ctrl #(
        .GateCycles(G2),
        .SettleCycles(S2),
        .ResetSel(1'b0)
    ) u_dut2 (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_i(req[2]),
        .sel_req_i(sel_req[2]),
        .sel_o(sel[2]),
        .clk_en_o(clk_en[2]),
        .busy_o(busy[2]),
        .ack_o(ack[2]),
        .req_drop_o(drop[2])
    );

    function automatic int g_of(input int i);
        case (i)
            0:       return G0;
            1:       return G1;
            default: return G2;
        endcase
    endfunction

    function automatic int s_of(input int i);
        case (i)
            0:       return S0;
            1:       return S1;
            default: return S2;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model state per instance:
    //   m_elapsed  - edges since the accept edge (1 in the first GATE cycle)
    //   m_active   - a switch or its ack cycle is still in view
    //   m_rst_edge - the last edge was a reset, so the select may jump
    //                while the gate is open
    int   m_elapsed [3];
    bit   m_active  [3];
    logic m_sel     [3];
    logic m_target  [3];
    logic m_noop_ack[3];
    logic m_drop    [3];
    bit   m_rst_edge[3];
    bit   model_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int g;
            int s;
            bit idle_now;
            g = g_of(i);
            s = s_of(i);
            if (!rst_n) begin
                m_active[i]   = 1'b0;
                m_elapsed[i]  = 0;
                m_sel[i]      = 1'b0;
                m_target[i]   = 1'b0;
                m_noop_ack[i] = 1'b0;
                m_drop[i]     = 1'b0;
                m_rst_edge[i] = 1'b1;
            end else begin
                m_rst_edge[i] = 1'b0;
                idle_now      = !m_active[i] || (m_elapsed[i] > g + s);
                m_drop[i]     = req[i] && !idle_now;
                m_noop_ack[i] = idle_now && req[i] && (sel_req[i] == m_sel[i]);
                if (idle_now && req[i] && (sel_req[i] != m_sel[i])) begin
                    m_active[i]  = 1'b1;
                    m_elapsed[i] = 1;
                    m_target[i]  = sel_req[i];
                end else if (m_active[i]) begin
                    m_elapsed[i]++;
                    if (m_elapsed[i] == g + 1) m_sel[i] = m_target[i];
                    if (m_elapsed[i] > g + s + 1) m_active[i] = 1'b0;
                end
            end
        end
        if (!rst_n) model_valid = 1'b1;
    end

    logic prev_sel[3];

    // Every-cycle comparison against the model, plus the rule that the
    // select only ever moves while the gate is closed (outside of reset).
    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 3; i++) begin
                logic e_busy;
                logic e_ack;
                e_busy = m_active[i] && (m_elapsed[i] <= g_of(i) + s_of(i));
                e_ack  = m_noop_ack[i] ||
                         (m_active[i] && (m_elapsed[i] == g_of(i) + s_of(i) + 1));
                checkOutput($sformatf("inst%0d_sel", i),    sel[i],    m_sel[i]);
                checkOutput($sformatf("inst%0d_clk_en", i), clk_en[i], !e_busy);
                checkOutput($sformatf("inst%0d_busy", i),   busy[i],   e_busy);
                checkOutput($sformatf("inst%0d_ack", i),    ack[i],    e_ack);
                checkOutput($sformatf("inst%0d_drop", i),   drop[i],   m_drop[i]);
                if (!m_rst_edge[i] && (sel[i] !== prev_sel[i])) begin
                    checkOutput($sformatf("inst%0d_en_at_sel_change", i), clk_en[i], 1'b0);
                end
                prev_sel[i] = sel[i];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle request on the selected instances. The call happens
    // in cycle 0 and returns in cycle 1.
    task automatic applyStimulus(input logic [2:0] mask, input logic [2:0] sel_vals);
        req     = mask;
        sel_req = sel_vals;
        tick();
        req     = 3'b000;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 3'b000;
        sel_req = 3'b000;

        // Reset for two edges, then idle.
        tick();
        tick();
        checkOutput("rst_sel",    sel[0],    1'b0);
        checkOutput("rst_clk_en", clk_en[0], 1'b1);
        checkOutput("rst_busy",   busy[0],   1'b0);
        checkOutput("rst_ack",    ack[0],    1'b0);
        checkOutput("rst_drop",   drop[0],   1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        checkOutput("idle_clk_en", clk_en[0], 1'b1);
        checkOutput("idle_sel",    sel[0],    1'b0);

        // Nominal switch to clk1 on all instances at once.
        applyStimulus(3'b111, 3'b111);
        for (int k = 1; k <= 512; k++) begin
            if (k <= 12) begin
                checkOutput($sformatf("nom0_en_c%0d", k),   clk_en[0], !(k >= 1 && k <= 8));
                checkOutput($sformatf("nom0_sel_c%0d", k),  sel[0],    k >= 5);
                checkOutput($sformatf("nom0_busy_c%0d", k), busy[0],   k >= 1 && k <= 8);
                checkOutput($sformatf("nom0_ack_c%0d", k),  ack[0],    k == 9);
                checkOutput($sformatf("nom1_ack_c%0d", k),  ack[1],    k == 3);
                checkOutput($sformatf("nom1_sel_c%0d", k),  sel[1],    k >= 2);
            end
            if (k == 255 || k == 256) begin
                checkOutput($sformatf("nom2_sel_c%0d", k), sel[2], k == 256);
            end
            if (k >= 510) begin
                checkOutput($sformatf("nom2_ack_c%0d", k), ack[2],    k == 511);
                checkOutput($sformatf("nom2_en_c%0d", k),  clk_en[2], k >= 511);
            end
            tick();
        end

        // No-op: inst0 already on clk1.
        applyStimulus(3'b001, 3'b111);
        checkOutput("noop_ack",  ack[0],    1'b1);
        checkOutput("noop_en",   clk_en[0], 1'b1);
        checkOutput("noop_sel",  sel[0],    1'b1);
        checkOutput("noop_busy", busy[0],   1'b0);
        tick();
        checkOutput("noop_ack_once", ack[0], 1'b0);

        // Request while busy: switch inst0 to clk0, retry toward clk1 in
        // cycle 3.
        applyStimulus(3'b001, 3'b000);
        tick();
        tick();
        applyStimulus(3'b001, 3'b001);
        checkOutput("busy_drop_c4", drop[0], 1'b1);
        tick();
        checkOutput("busy_drop_c5", drop[0], 1'b0);
        for (int k = 5; k < 9; k++) tick();
        checkOutput("busy_ack_c9", ack[0],    1'b1);
        checkOutput("busy_sel_c9", sel[0],    1'b0);
        checkOutput("busy_en_c9",  clk_en[0], 1'b1);
        tick();

        // Back-to-back: inst0 0->1 then 1->0 in ack cycle 9;
        // inst1 1->0 then 0->1 in ack cycle 3.
        for (int k = 0; k <= 20; k++) begin
            if (k == 9) begin
                checkOutput("b2b0_ack_c9", ack[0],    1'b1);
                checkOutput("b2b0_en_c9",  clk_en[0], 1'b1);
            end
            if (k == 10) begin
                checkOutput("b2b0_en_c10",   clk_en[0], 1'b0);
                checkOutput("b2b0_busy_c10", busy[0],   1'b1);
            end
            if (k == 18) begin
                checkOutput("b2b0_ack_c18", ack[0], 1'b1);
                checkOutput("b2b0_sel_c18", sel[0], 1'b0);
            end
            if (k == 3) checkOutput("b2b1_ack_c3", ack[1],    1'b1);
            if (k == 4) checkOutput("b2b1_en_c4",  clk_en[1], 1'b0);
            if (k == 6) begin
                checkOutput("b2b1_ack_c6", ack[1], 1'b1);
                checkOutput("b2b1_sel_c6", sel[1], 1'b1);
            end
            req     = 3'b000;
            sel_req = 3'b000;
            if (k == 0) begin
                req[0] = 1'b1; sel_req[0] = 1'b1;
                req[1] = 1'b1; sel_req[1] = 1'b0;
            end
            if (k == 9) begin
                req[0] = 1'b1; sel_req[0] = 1'b0;
            end
            if (k == 3) begin
                req[1] = 1'b1; sel_req[1] = 1'b1;
            end
            tick();
        end
        req = 3'b000;

        // Reset in cycle 6 of an inst0 switch toward clk1.
        for (int k = 0; k <= 20; k++) begin
            if (k == 5) checkOutput("mid_sel_c5", sel[0], 1'b1);
            if (k == 7) begin
                rst_n = 1'b1;
                checkOutput("mid_sel_c7",  sel[0],    1'b0);
                checkOutput("mid_en_c7",   clk_en[0], 1'b1);
                checkOutput("mid_busy_c7", busy[0],   1'b0);
            end
            if (k >= 7) checkOutput($sformatf("mid_no_ack_c%0d", k), ack[0], 1'b0);
            req     = 3'b000;
            sel_req = 3'b000;
            if (k == 0) begin
                req[0] = 1'b1; sel_req[0] = 1'b1;
            end
            if (k == 6) rst_n = 1'b0;
            tick();
        end

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
